reservation_station: RTL and testbench

//  Tomasulo reservation station directly downstream of the issue stage. Accepts one issued

---
 rtl/reservation_station_pkg.sv | 34 +++
 rtl/reservation_station_if.sv | 41 ++++
 rtl/reservation_station_rs_entry.sv | 99 +++++++++
 rtl/reservation_station.sv | 99 +++++++++
 tb/tb_reservation_station.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reservation_station_pkg.sv
// Shared widths, label conventions and ALU op codes for the issue stage,
// the reservation station and the ALU.
package reservation_station_pkg;

    localparam int LABEL_W = 5;
    localparam int DATA_W  = 32;
    localparam int OP_W    = 6;

    typedef logic [LABEL_W-1:0] label_t;
    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [OP_W-1:0]    op_t;

    localparam label_t NO_LABEL = '0;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 6'h20,
        ALU_ADDU = 6'h21,
        ALU_SUB  = 6'h22,
        ALU_SUBU = 6'h23,
        ALU_AND  = 6'h24,
        ALU_OR   = 6'h25,
        ALU_XOR  = 6'h26,
        ALU_NOR  = 6'h27,
        ALU_SLT  = 6'h2A,
        ALU_SLTU = 6'h2B
    } alu_op_e;

    // Label 0 means "value valid", so it can never be woken by a broadcast.
    function automatic logic cdb_hit(input logic cdb_valid, input label_t cdb_label,
                                     input label_t lab);
        return cdb_valid && (lab != NO_LABEL) && (lab == cdb_label);
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Issue, common-data-bus and functional-unit signals of one reservation station.
// The slave modport is the station; the master modport is its surroundings.
interface reservation_station_if import reservation_station_pkg::*; ();

    logic   issueValid;
    logic   issueReady;
    label_t issueTag;
    op_t    issueOp;
    label_t issueLabel1;
    data_t  issueValue1;
    label_t issueLabel2;
    data_t  issueValue2;

    logic   cdbValid;
    label_t cdbLabel;
    data_t  cdbData;

    logic   exValid;
    logic   exReady;
    op_t    exOp;
    data_t  exA;
    data_t  exB;
    label_t exTag;

    modport slave (
        input  issueValid, issueOp, issueLabel1, issueValue1, issueLabel2, issueValue2,
        input  cdbValid, cdbLabel, cdbData,
        input  exReady,
        output issueReady, issueTag,
        output exValid, exOp, exA, exB, exTag
    );

    modport master (
        output issueValid, issueOp, issueLabel1, issueValue1, issueLabel2, issueValue2,
        output cdbValid, cdbLabel, cdbData,
        output exReady,
        input  issueReady, issueTag,
        input  exValid, exOp, exA, exB, exTag
    );

endinterface

// File: rtl/reservation_station_rs_entry.sv
// One reservation-station entry: operand capture at issue (with same-cycle CDB
// bypass), CDB snooping for pending operands, and release on dispatch.
module rs_entry import reservation_station_pkg::*; (
    input  logic   clk,
    input  logic   rst,
    input  logic   issue_we,
    input  op_t    issue_op,
    input  label_t issue_lab1,
    input  data_t  issue_val1,
    input  label_t issue_lab2,
    input  data_t  issue_val2,
    input  logic   cdb_valid,
    input  label_t cdb_label,
    input  data_t  cdb_data,
    input  logic   dispatch_clr,
    output logic   busy,
    output logic   ready,
    output op_t    op,
    output data_t  val1,
    output data_t  val2
);

    logic   busy_q, busy_d;
    op_t    op_q, op_d;
    label_t lab1_q, lab1_d;
    label_t lab2_q, lab2_d;
    data_t  val1_q, val1_d;
    data_t  val2_q, val2_d;

    always_comb begin
        busy_d = busy_q;
        op_d   = op_q;
        lab1_d = lab1_q;
        lab2_d = lab2_q;
        val1_d = val1_q;
        val2_d = val2_q;

        if (busy_q) begin
            if (cdb_hit(cdb_valid, cdb_label, lab1_q)) begin
                lab1_d = NO_LABEL;
                val1_d = cdb_data;
            end
            if (cdb_hit(cdb_valid, cdb_label, lab2_q)) begin
                lab2_d = NO_LABEL;
                val2_d = cdb_data;
            end
        end

        if (dispatch_clr) begin
            busy_d = 1'b0;
        end

        // The issuer's register status lags one cycle, so a producer broadcasting
        // right now must be captured here or its result would be missed forever.
        if (issue_we) begin
            busy_d = 1'b1;
            op_d   = issue_op;
            if (cdb_hit(cdb_valid, cdb_label, issue_lab1)) begin
                lab1_d = NO_LABEL;
                val1_d = cdb_data;
            end else begin
                lab1_d = issue_lab1;
                val1_d = issue_val1;
            end
            if (cdb_hit(cdb_valid, cdb_label, issue_lab2)) begin
                lab2_d = NO_LABEL;
                val2_d = cdb_data;
            end else begin
                lab2_d = issue_lab2;
                val2_d = issue_val2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            op_q   <= '0;
            lab1_q <= NO_LABEL;
            lab2_q <= NO_LABEL;
            val1_q <= '0;
            val2_q <= '0;
        end else begin
            busy_q <= busy_d;
            op_q   <= op_d;
            lab1_q <= lab1_d;
            lab2_q <= lab2_d;
            val1_q <= val1_d;
            val2_q <= val2_d;
        end
    end

    assign busy  = busy_q;
    assign ready = busy_q && (lab1_q == NO_LABEL) && (lab2_q == NO_LABEL);
    assign op    = op_q;
    assign val1  = val1_q;
    assign val2  = val2_q;

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: lowest-free-entry issue, CDB wake-up inside the
// entries, and lowest-ready-entry dispatch tagged with the entry's own label.
module reservation_station import reservation_station_pkg::*; #(
    parameter int DEPTH    = 3,
    parameter int BASE_TAG = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    reservation_station_if.slave   bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] issue_we;
    logic [DEPTH-1:0] dispatch_clr;
    op_t              op_arr   [DEPTH];
    data_t            val1_arr [DEPTH];
    data_t            val2_arr [DEPTH];
    label_t           label_arr[DEPTH];

    logic             any_free;
    logic             any_ready;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] ready_idx;
    logic             issue_fire;
    logic             dispatch_fire;

    // Both encoders see pre-edge state only, so an entry freed by this cycle's
    // dispatch cannot be reused before the next cycle.
    always_comb begin
        any_free  = 1'b0;
        free_idx  = '0;
        any_ready = 1'b0;
        ready_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (ready[i]) begin
                any_ready = 1'b1;
                ready_idx = IDX_W'(i);
            end
        end
    end

    assign issue_fire    = bus.issueValid && any_free;
    assign dispatch_fire = any_ready && bus.exReady;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign label_arr[gi]    = LABEL_W'(BASE_TAG + gi);
            assign issue_we[gi]     = issue_fire && (free_idx == IDX_W'(gi));
            assign dispatch_clr[gi] = dispatch_fire && (ready_idx == IDX_W'(gi));

            rs_entry u_entry (
                .clk          (clk),
                .rst          (rst),
                .issue_we     (issue_we[gi]),
                .issue_op     (bus.issueOp),
                .issue_lab1   (bus.issueLabel1),
                .issue_val1   (bus.issueValue1),
                .issue_lab2   (bus.issueLabel2),
                .issue_val2   (bus.issueValue2),
                .cdb_valid    (bus.cdbValid),
                .cdb_label    (bus.cdbLabel),
                .cdb_data     (bus.cdbData),
                .dispatch_clr (dispatch_clr[gi]),
                .busy         (busy[gi]),
                .ready        (ready[gi]),
                .op           (op_arr[gi]),
                .val1         (val1_arr[gi]),
                .val2         (val2_arr[gi])
            );
        end
    endgenerate

    always_comb begin
        bus.issueReady = any_free;
        bus.issueTag   = label_arr[0];
        bus.exValid    = any_ready;
        bus.exOp       = '0;
        bus.exA        = '0;
        bus.exB        = '0;
        bus.exTag      = label_arr[0];
        if (any_free) begin
            bus.issueTag = label_arr[free_idx];
        end
        if (any_ready) begin
            bus.exOp  = op_arr[ready_idx];
            bus.exA   = val1_arr[ready_idx];
            bus.exB   = val2_arr[ready_idx];
            bus.exTag = label_arr[ready_idx];
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed scenarios followed by random traffic, all checked against an
// entry-table reference model of the reservation station.
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int DEPTH    = 3;
    localparam int BASE_TAG = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reservation_station_if bus();

    reservation_station #(.DEPTH(DEPTH), .BASE_TAG(BASE_TAG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [4:0]  l1;
        logic [4:0]  l2;
        logic [31:0] v1;
        logic [31:0] v2;
    } ment_t;

    ment_t m[DEPTH];
    int n_vec  = 0;
    int n_miss = 0;

    function automatic int first_free();
        for (int i = 0; i < DEPTH; i++) if (!m[i].busy) return i;
        return -1;
    endfunction

    function automatic int first_ready();
        for (int i = 0; i < DEPTH; i++)
            if (m[i].busy && m[i].l1 == 5'd0 && m[i].l2 == 5'd0) return i;
        return -1;
    endfunction

    function automatic bit bcast(input logic [4:0] lab);
        return bus.cdbValid && lab != 5'd0 && lab == bus.cdbLabel;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m[i] = '{busy: 0, op: '0, l1: '0, l2: '0, v1: '0, v2: '0};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ctx);
        int f = first_free();
        int r = first_ready();
        chk({ctx, ".issueReady"}, 32'(bus.issueReady), 32'(f >= 0));
        chk({ctx, ".issueTag"},   32'(bus.issueTag),   32'((f >= 0) ? BASE_TAG + f : BASE_TAG));
        chk({ctx, ".exValid"},    32'(bus.exValid),    32'(r >= 0));
        chk({ctx, ".exOp"},       32'(bus.exOp),       (r >= 0) ? 32'(m[r].op) : 32'd0);
        chk({ctx, ".exA"},        bus.exA,             (r >= 0) ? m[r].v1 : 32'd0);
        chk({ctx, ".exB"},        bus.exB,             (r >= 0) ? m[r].v2 : 32'd0);
        chk({ctx, ".exTag"},      32'(bus.exTag),      32'((r >= 0) ? BASE_TAG + r : BASE_TAG));
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick(input string ctx);
        ment_t nx[DEPTH];
        int f = first_free();
        int r = first_ready();
        check_outputs(ctx);
        nx = m;
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i].busy && bcast(m[i].l1)) begin nx[i].l1 = 5'd0; nx[i].v1 = bus.cdbData; end
            if (m[i].busy && bcast(m[i].l2)) begin nx[i].l2 = 5'd0; nx[i].v2 = bus.cdbData; end
        end
        if (r >= 0 && bus.exReady) nx[r].busy = 0;
        if (bus.issueValid && f >= 0) begin
            nx[f].busy = 1;
            nx[f].op   = bus.issueOp;
            nx[f].l1   = bcast(bus.issueLabel1) ? 5'd0 : bus.issueLabel1;
            nx[f].v1   = bcast(bus.issueLabel1) ? bus.cdbData : bus.issueValue1;
            nx[f].l2   = bcast(bus.issueLabel2) ? 5'd0 : bus.issueLabel2;
            nx[f].v2   = bcast(bus.issueLabel2) ? bus.cdbData : bus.issueValue2;
        end
        @(posedge clk);
        m = nx;
        @(negedge clk);
    endtask

    task automatic issue(input logic [5:0] op, input logic [4:0] l1, input logic [31:0] v1,
                         input logic [4:0] l2, input logic [31:0] v2);
        bus.issueValid  = 1'b1;
        bus.issueOp     = op;
        bus.issueLabel1 = l1;
        bus.issueValue1 = v1;
        bus.issueLabel2 = l2;
        bus.issueValue2 = v2;
    endtask

    task automatic no_issue();
        bus.issueValid = 1'b0;
    endtask

    task automatic cdb(input logic [4:0] lab, input logic [31:0] data);
        bus.cdbValid = 1'b1;
        bus.cdbLabel = lab;
        bus.cdbData  = data;
    endtask

    task automatic no_cdb();
        bus.cdbValid = 1'b0;
    endtask

    logic [4:0] lab_pool [8] = '{5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd9, 5'd10, 5'd11};
    logic [4:0] cdb_pool [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd9, 5'd10, 5'd11, 5'd12};

    initial begin
        rst = 1'b1;
        bus.issueValid = 0; bus.issueOp = '0;
        bus.issueLabel1 = '0; bus.issueValue1 = '0;
        bus.issueLabel2 = '0; bus.issueValue2 = '0;
        bus.cdbValid = 0; bus.cdbLabel = '0; bus.cdbData = '0;
        bus.exReady = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset.issueReady", 32'(bus.issueReady), 32'd1);
        chk("reset.issueTag",   32'(bus.issueTag),   32'd1);
        chk("reset.exValid",    32'(bus.exValid),    32'd0);
        chk("reset.exOp",       32'(bus.exOp),       32'd0);
        chk("reset.exA",        bus.exA,             32'd0);
        chk("reset.exB",        bus.exB,             32'd0);
        chk("reset.exTag",      32'(bus.exTag),      32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Ready operands: dispatchable one cycle after issue.
        issue(ALU_ADD, 5'd0, 32'd5, 5'd0, 32'd7);
        tick("t2.issue");
        no_issue();
        chk("t2.exValid", 32'(bus.exValid), 32'd1);
        chk("t2.exA",     bus.exA,          32'd5);
        chk("t2.exB",     bus.exB,          32'd7);
        chk("t2.exTag",   32'(bus.exTag),   32'd1);
        chk("t2.exOp",    32'(bus.exOp),    32'h20);
        bus.exReady = 1'b1;
        tick("t2.dispatch");
        bus.exReady = 1'b0;
        chk("t2.freed", 32'(bus.issueReady), 32'd1);
        chk("t2.empty", 32'(bus.exValid),    32'd0);

        // Operand A waits on label 9.
        issue(ALU_SUB, 5'd9, 32'hDEAD, 5'd0, 32'd3);
        tick("t3.issue");
        no_issue();
        tick("t3.wait");
        chk("t3.waiting", 32'(bus.exValid), 32'd0);
        cdb(5'd9, 32'd100);
        tick("t3.cdb");
        no_cdb();
        chk("t3.exValid", 32'(bus.exValid), 32'd1);
        chk("t3.exA",     bus.exA,          32'd100);
        chk("t3.exB",     bus.exB,          32'd3);
        bus.exReady = 1'b1;
        tick("t3.dispatch");
        bus.exReady = 1'b0;

        // Producer broadcasts in the issue cycle itself.
        issue(ALU_AND, 5'd9, 32'd0, 5'd0, 32'd1);
        cdb(5'd9, 32'd42);
        tick("t4.issue");
        no_issue();
        no_cdb();
        chk("t4.exValid", 32'(bus.exValid), 32'd1);
        chk("t4.exA",     bus.exA,          32'd42);
        bus.exReady = 1'b1;
        tick("t4.dispatch");
        bus.exReady = 1'b0;

        // Fill the station, then free the middle entry.
        issue(ALU_OR,  5'd9,  32'd0, 5'd0, 32'd11); tick("t5.i0");
        issue(ALU_XOR, 5'd10, 32'd0, 5'd0, 32'd22); tick("t5.i1");
        issue(ALU_NOR, 5'd11, 32'd0, 5'd0, 32'd33); tick("t5.i2");
        chk("t5.full.issueReady", 32'(bus.issueReady), 32'd0);
        chk("t5.full.issueTag",   32'(bus.issueTag),   32'd1);
        issue(ALU_ADD, 5'd0, 32'd1, 5'd0, 32'd2);
        tick("t5.ignored");
        chk("t5.ignored.exValid", 32'(bus.exValid), 32'd0);
        no_issue();
        cdb(5'd10, 32'd77);
        tick("t5.cdb");
        no_cdb();
        chk("t5.exTag", 32'(bus.exTag), 32'd2);
        chk("t5.exA",   bus.exA,        32'd77);
        issue(ALU_ADD, 5'd0, 32'd1, 5'd0, 32'd2);
        bus.exReady = 1'b1;
        tick("t5.dispatch");
        no_issue();
        bus.exReady = 1'b0;
        chk("t5.after.issueReady", 32'(bus.issueReady), 32'd1);
        chk("t5.after.issueTag",   32'(bus.issueTag),   32'd2);
        cdb(5'd9, 32'd1);  tick("t5.drain9");
        cdb(5'd11, 32'd2); tick("t5.drain11");
        no_cdb();
        bus.exReady = 1'b1;
        tick("t5.drain.d0");
        tick("t5.drain.d1");
        bus.exReady = 1'b0;
        chk("t5.drained", 32'(bus.issueTag), 32'd1);

        // Entries 0 and 2 ready, entry 1 pending; back-pressure then two dispatches.
        issue(ALU_SUB, 5'd0, 32'd100, 5'd0, 32'd200); tick("t6.i0");
        issue(ALU_AND, 5'd12, 32'd0, 5'd0, 32'd1);    tick("t6.i1");
        issue(ALU_OR,  5'd0, 32'd300, 5'd0, 32'd400); tick("t6.i2");
        no_issue();
        for (int k = 0; k < 3; k++) begin
            chk("t6.hold.exTag", 32'(bus.exTag), 32'd1);
            chk("t6.hold.exA",   bus.exA,        32'd100);
            chk("t6.hold.exB",   bus.exB,        32'd200);
            tick("t6.hold");
        end
        bus.exReady = 1'b1;
        chk("t6.first.exTag", 32'(bus.exTag), 32'd1);
        tick("t6.d1");
        chk("t6.second.exTag", 32'(bus.exTag), 32'd3);
        chk("t6.second.exA",   bus.exA,        32'd300);
        tick("t6.d3");
        bus.exReady = 1'b0;
        chk("t6.none", 32'(bus.exValid), 32'd0);
        cdb(5'd12, 32'd5); tick("t6.cdb");
        no_cdb();
        bus.exReady = 1'b1; tick("t6.d2");
        bus.exReady = 1'b0;

        // Asynchronous reset with two pending entries.
        issue(ALU_ADD, 5'd20, 32'd0, 5'd0, 32'd1); tick("t1.i0");
        issue(ALU_ADD, 5'd21, 32'd0, 5'd0, 32'd2); tick("t1.i1");
        no_issue();
        chk("t1.pre.issueTag", 32'(bus.issueTag), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("t1.rst.issueReady", 32'(bus.issueReady), 32'd1);
        chk("t1.rst.exValid",    32'(bus.exValid),    32'd0);
        chk("t1.rst.issueTag",   32'(bus.issueTag),   32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cdb(5'd20, 32'd9);
        tick("t1.post");
        no_cdb();
        chk("t1.no_dispatch", 32'(bus.exValid), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 1) == 1)
                issue(6'($urandom_range(32, 43)), lab_pool[$urandom_range(0, 7)], $urandom(),
                      lab_pool[$urandom_range(0, 7)], $urandom());
            else
                no_issue();
            if ($urandom_range(0, 1) == 1) cdb(cdb_pool[$urandom_range(0, 7)], $urandom());
            else no_cdb();
            bus.exReady = ($urandom_range(0, 2) != 0);
            tick("rand");
        end
        no_issue();
        no_cdb();
        bus.exReady = 1'b0;
        check_outputs("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
